// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder
// Feeds the west edge of a systolic array. Each accepted activation vector
// carries one element per array row; row r is emitted r cycles after row 0
// so that the PE grid sees the diagonal wavefront it expects. Per-row valid
// and weight-switch strobes travel with the data. A one-cycle done pulse
// marks the cycle in which the last skewed element of a tile leaves.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream vector valid
//   in_ready    feeder can accept (low only while a tile drains)
//   in_data     ROWS*DATA_WIDTH, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_last     vector closes the tile
//   in_switch   promote background weights (first vector of a tile only)
//   feed_input  skewed elements to column-0 PEs, same packing as in_data
//   feed_valid  per-row valid strobe
//   feed_switch per-row weight-switch strobe
//   vec_count   vectors accepted in current/last tile, saturating
//   done        one-cycle tile-complete pulse
module systolic_input_feeder #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  input  logic                       in_switch,
  output logic [ROWS*DATA_WIDTH-1:0] feed_input,
  output logic [ROWS-1:0]            feed_valid,
  output logic [ROWS-1:0]            feed_switch,
  output logic [CNT_WIDTH-1:0]       vec_count,
  output logic                       done
);

  // Drain counter must hold ROWS-1; one spare bit keeps ROWS=1 legal.
  localparam int DCW = (ROWS > 1) ? $clog2(ROWS) + 1 : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state_r;
  logic [DCW-1:0]       drain_cnt_r;
  logic [CNT_WIDTH-1:0] vec_count_r;
  logic                 done_r;
  logic                 xfer_s;
  logic                 switch_s;

  // Saturating increment of the tile vector counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Ready depends on state only so upstream never sees a comb path from in_valid.
  assign in_ready = (state_r != DRAIN);
  assign xfer_s   = in_valid && in_ready;
  // Weight switch is only honoured on the vector that opens a tile.
  assign switch_s = xfer_s && in_switch && (state_r == IDLE);

  // Tile FSM: tracks open tile, counts vectors, times the drain and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      drain_cnt_r <= {DCW{1'b0}};
      vec_count_r <= {CNT_WIDTH{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, STREAM: begin
          if (xfer_s) begin
            if (state_r == IDLE) begin
              vec_count_r <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              vec_count_r <= sat_inc(vec_count_r);
            end
            if (!in_last) begin
              state_r <= STREAM;
            end else if (ROWS == 1) begin
              // Single lane: the element leaves on this very edge.
              state_r <= IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= DRAIN;
              drain_cnt_r <= DCW'(ROWS - 1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DCW'(1)) begin
            state_r     <= IDLE;
            drain_cnt_r <= {DCW{1'b0}};
            done_r      <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - DCW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          drain_cnt_r <= {DCW{1'b0}};
        end
      endcase
    end
  end

  assign vec_count = vec_count_r;
  assign done      = done_r;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_r [0:r];
    logic [r:0]            valid_r;
    logic [r:0]            switch_r;

    // Lane r skew chain of r+1 stages; empty slots carry zero data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= r; s++) begin
          data_r[s]   <= {DATA_WIDTH{1'b0}};
          valid_r[s]  <= 1'b0;
          switch_r[s] <= 1'b0;
        end
      end else begin
        data_r[0]   <= xfer_s ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
        valid_r[0]  <= xfer_s;
        switch_r[0] <= switch_s;
        for (int s = 1; s <= r; s++) begin
          data_r[s]   <= data_r[s-1];
          valid_r[s]  <= valid_r[s-1];
          switch_r[s] <= switch_r[s-1];
        end
      end
    end

    assign feed_input[r*DATA_WIDTH +: DATA_WIDTH] = data_r[r];
    assign feed_valid[r]  = valid_r[r];
    assign feed_switch[r] = switch_r[r];
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed testbench for systolic_input_feeder (ROWS=2, DATA_WIDTH=16).
// A second instance with CNT_WIDTH=2 shares all inputs and is used for the
// vec_count saturation scenario.
module tb_systolic_input_feeder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_switch;
  logic [31:0] feed_input;
  logic [1:0]  feed_valid;
  logic [1:0]  feed_switch;
  logic [7:0]  vec_count;
  logic        done;

  logic        s_in_ready;
  logic [31:0] s_feed_input;
  logic [1:0]  s_feed_valid;
  logic [1:0]  s_feed_switch;
  logic [1:0]  s_vec_count;
  logic        s_done;

  int errors = 0;
  int checks = 0;

  systolic_input_feeder #(.ROWS(2), .DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_switch(in_switch),
    .feed_input(feed_input), .feed_valid(feed_valid), .feed_switch(feed_switch),
    .vec_count(vec_count), .done(done)
  );

  systolic_input_feeder #(.ROWS(2), .DATA_WIDTH(16), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_last(in_last), .in_switch(in_switch),
    .feed_input(s_feed_input), .feed_valid(s_feed_valid), .feed_switch(s_feed_switch),
    .vec_count(s_vec_count), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r0, input logic [15:0] r1,
                       input logic l, input logic sw);
    in_valid  = v;
    in_data   = {r1, r0};
    in_last   = l;
    in_switch = sw;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    checks++;
    if ({feed_input, feed_valid, feed_switch, vec_count, done} !== 45'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {feed_input, feed_valid, feed_switch, vec_count, done});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b1);
    step();  // edge 0
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (feed_input[15:0] !== 16'h0100 || feed_valid !== 2'b01 || feed_switch !== 2'b01) begin
      errors++;
      $display("FAIL single_e0 got=%h/%b/%b want=0100/01/01", feed_input[15:0], feed_valid, feed_switch);
    end
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || vec_count !== 8'd1) begin
      errors++;
      $display("FAIL single_e0_ctl got rdy=%b done=%b cnt=%0d want 0/0/1", in_ready, done, vec_count);
    end
    step();  // edge 1
    checks++;
    if (feed_input !== 32'h0200_0000 || feed_valid !== 2'b10 || feed_switch !== 2'b10) begin
      errors++;
      $display("FAIL single_e1 got=%h/%b/%b want=02000000/10/10", feed_input, feed_valid, feed_switch);
    end
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done got done=%b rdy=%b want 1/1", done, in_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || feed_valid !== 2'b00 || feed_input !== 32'h0) begin
      errors++;
      $display("FAIL single_after got done=%b v=%b d=%h want 0/00/0", done, feed_valid, feed_input);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i + 1), 16'(i + 17), (i == 3), 1'b0);
      step();
      checks++;
      if (feed_valid[0] !== 1'b1 || feed_input[15:0] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL b2b_lane0[%0d] got v=%b d=%h want 1/%h", i, feed_valid[0], feed_input[15:0], 16'(i + 1));
      end
      checks++;
      if (feed_valid[1] !== (i > 0) || feed_input[31:16] !== ((i > 0) ? 16'(i + 16) : 16'h0)) begin
        errors++;
        $display("FAIL b2b_lane1[%0d] got v=%b d=%h", i, feed_valid[1], feed_input[31:16]);
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (vec_count !== 8'd4) begin errors++; $display("FAIL b2b_count got=%0d want=4", vec_count); end
    step();
    checks++;
    if (feed_valid !== 2'b10 || feed_input[31:16] !== 16'h0014 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_tail got v=%b d=%h done=%b want 10/0014/1", feed_valid, feed_input[31:16], done);
    end
    step();
  endtask

  task automatic test_switch_second();
    drive(1'b1, 16'h0031, 16'h0041, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0032, 16'h0042, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      checks++;
      if (feed_switch !== 2'b00) begin
        errors++;
        $display("FAIL switch_second[%0d] got=%b want=00", i, feed_switch);
      end
    end
  endtask

  task automatic test_gaps();
    logic [1:0]  exp_v [4];
    logic [31:0] exp_d [4];
    exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{32'h0000_000A, 32'h001A_0000, 32'h0000_000B, 32'h001B_0000};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, 16'h000A, 16'h001A, 1'b0, 1'b0);
        2: drive(1'b1, 16'h000B, 16'h001B, 1'b1, 1'b0);
        default: drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      endcase
      step();
      checks++;
      if (feed_valid !== exp_v[i] || feed_input !== exp_d[i]) begin
        errors++;
        $display("FAIL gaps[%0d] got v=%b d=%h want v=%b d=%h", i, feed_valid, feed_input, exp_v[i], exp_d[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || vec_count !== 8'd2) begin
      errors++;
      $display("FAIL gaps_done got done=%b cnt=%0d want 1/2", done, vec_count);
    end
    step();
  endtask

  task automatic test_hold_drain();
    drive(1'b1, 16'h0051, 16'h0061, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0052, 16'h0062, 1'b1, 1'b0);
    step();  // edge L
    drive(1'b1, 16'h0071, 16'h0081, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || vec_count !== 8'd2) begin
      errors++;
      $display("FAIL hold_L got rdy=%b cnt=%0d want 0/2", in_ready, vec_count);
    end
    step();  // edge L+1: no transfer
    checks++;
    if (feed_valid !== 2'b10 || in_ready !== 1'b1 || done !== 1'b1 || vec_count !== 8'd2) begin
      errors++;
      $display("FAIL hold_L1 got v=%b rdy=%b done=%b cnt=%0d want 10/1/1/2", feed_valid, in_ready, done, vec_count);
    end
    step();  // edge L+2: next tile opens
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (feed_valid !== 2'b01 || feed_input[15:0] !== 16'h0071 || vec_count !== 8'd1) begin
      errors++;
      $display("FAIL hold_L2 got v=%b d=%h cnt=%0d want 01/0071/1", feed_valid, feed_input[15:0], vec_count);
    end
  endtask

  task automatic test_reset_mid_tile();
    // Tile opened by test_hold_drain is still streaming.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({feed_input, feed_valid, feed_switch, vec_count, done} !== 45'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async got=%h rdy=%b want 0/1", {feed_input, feed_valid, feed_switch, vec_count, done}, in_ready);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || feed_valid !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done[%0d] got done=%b v=%b want 0/00", i, done, feed_valid);
      end
    end
    drive(1'b1, 16'h0091, 16'h00A1, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (vec_count !== 8'd1 || feed_switch !== 2'b01 || feed_input[15:0] !== 16'h0091) begin
      errors++;
      $display("FAIL reset_fresh got cnt=%0d sw=%b d=%h want 1/01/0091", vec_count, feed_switch, feed_input[15:0]);
    end
    step();
    checks++;
    if (done !== 1'b1 || feed_switch !== 2'b10) begin
      errors++;
      $display("FAIL reset_fresh_done got done=%b sw=%b want 1/10", done, feed_switch);
    end
    step();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(i), 16'(i), (i == 4), 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (s_vec_count !== 2'd3) begin errors++; $display("FAIL sat_count got=%0d want=3", s_vec_count); end
    checks++;
    if (vec_count !== 8'd5) begin errors++; $display("FAIL wide_count got=%0d want=5", vec_count); end
    step();
    checks++;
    if (s_done !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL sat_done got=%b/%b want 1/1", s_done, done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_switch_second();
    test_gaps();
    test_hold_drain();
    test_reset_mid_tile();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

Upstream feeder for the west edge of the systolic array. It accepts one activation vector per handshake, with one element per array row. It emits row r of each vector r cycles after row 0, producing the diagonal skew the PE grid needs. Alongside the data it drives each row's valid and weight-switch strobes into column-0 PEs, and it reports tile completion once the last skewed element has left.

## Interface
- ROWS, 2: array rows (≥1); one skew lane per row.
- DATA_WIDTH, 16: signed element width (Q-format matches PE datapath).
- CNT_WIDTH, 8: width of vec_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  feeder can accept.
- in_data  in  ROWS*DATA_WIDTH  row r element at bits [r*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  1  this vector is the last of the tile.
- in_switch  in  1  promote background weights with this vector (honoured on first vector of a tile only).
- feed_input  out  ROWS*DATA_WIDTH  skewed elements to column-0 PE pe_input_in, same packing.
- feed_valid  out  ROWS  per-row pe_valid_in.
- feed_switch  out  ROWS  per-row pe_switch_in.
- vec_count  out  CNT_WIDTH  vectors accepted in current/last tile, saturating.
- done  out  1  one-cycle tile-complete pulse.

## Operation
- Transfer occurs on a rising edge with in_valid && in_ready; no transfer otherwise.
- FSM states: IDLE (no open tile), STREAM (tile open), DRAIN (last vector accepted, skew emptying).
- IDLE + transfer: clear vec_count to 1. If in_last, go to DRAIN (ROWS>1) or stay in IDLE with done (ROWS=1). Otherwise go to STREAM. Latch in_switch for this vector.
- STREAM + transfer: vec_count increments, saturating at 2^CNT_WIDTH−1. in_switch is ignored (treated 0). in_last moves to DRAIN, or to IDLE with done when ROWS=1.
- DRAIN: drain counter is loaded with ROWS−1 on the last transfer and decrements each edge. On the edge where it reads 1: go to IDLE and register done=1.
- in_ready = (state != DRAIN), combinational from state only.
- Skew: lane r is an (r+1)-stage register chain carrying {element, valid, switch}. Row 0 has a single register stage.
- Idle lane slots: feed_valid=0, feed_switch=0, and feed_input forced to 0 (PE psum zeroing convention).
- No backpressure from the array; once accepted, data always drains.

## Timing
- Vector accepted at edge k: lane r outputs change at edge k+r. Row 0 latency is 1 cycle from the input sample.
- feed_switch[r] is high exactly in the cycle feed_valid[r] carries the switched vector's row r.
- Last vector accepted at edge L: in_ready is low during cycles after edges L .. L+ROWS−2 (ROWS−1 cycles). The earliest next accept is edge L+ROWS.
- done is high in the single cycle after edge L+ROWS−1, coinciding with feed_valid[ROWS−1] of the last vector.
- Back-to-back transfers in STREAM give continuous feed_valid on every lane with no bubbles.
- Reset values (async on rst_n low): state IDLE, all skew registers 0, feed_input 0, feed_valid 0, feed_switch 0, vec_count 0, done 0, in_ready 1 once in IDLE.
- Reset mid-tile discards in-flight data; no done is generated for the aborted tile.

## Test plan
- ROWS=2, single vector {row0=0x0100, row1=0x0200}, last=1, switch=1, at edge 0 -> expected response:
  - edge 0: feed_input row0=0x0100 with feed_valid[0]=1 and feed_switch[0]=1.
  - edge 1: row1=0x0200 with valid[1]=1 and switch[1]=1, and done=1.
  - in_ready is low for 1 cycle.
- Four back-to-back vectors 1..4 (row1 = row0+0x10), last on 4th -> expected response:
  - lane0 valid for 4 consecutive cycles; lane1 the same, one cycle later.
  - vec_count=4; done aligned with lane1's value 0x14.
- in_switch=1 on 2nd vector of a tile -> feed_switch stays 0 on all lanes.
- Idle gaps: in_valid toggles 1,0,1 -> feed_valid shows the matching bubble per lane, and feed_input=0 during bubbles.
- in_valid held high through DRAIN -> no transfer while in_ready=0; the next tile's first vector is accepted at edge L+2 and restarts vec_count at 1.
- rst_n asserted one cycle after a mid-tile accept -> all outputs 0 immediately (asynchronously); no done afterward; the next accept after release behaves as a fresh tile.
- vec_count saturation with CNT_WIDTH=2: a 5-vector tile reports 3.
